// File: rtl/matmul_seq_if.sv
// Handshake/control bundle between the matrix-multiply sequencer and its datapath/host.
// Widths follow the matrix dimension N.
interface matmul_seq_if #(parameter int N = 3);
  localparam int IW = $clog2(N*N);
  localparam int LW = $clog2(2*N*N);

  logic          start, clear;
  logic          in_valid, in_ready, load_en;
  logic [LW-1:0] load_sel;
  logic          mac_clr, mac_en;
  logic [IW-1:0] a_sel, b_sel;
  logic          out_valid, out_ready;
  logic [IW-1:0] out_idx;
  logic          busy, done;

  modport master (output start, clear, in_valid, out_ready,
                  input  in_ready, load_en, load_sel, mac_clr, mac_en, a_sel, b_sel,
                         out_valid, out_idx, busy, done);
  modport slave  (input  start, clear, in_valid, out_ready,
                  output in_ready, load_en, load_sel, mac_clr, mac_en, a_sel, b_sel,
                         out_valid, out_idx, busy, done);
endinterface

// File: rtl/matmul_seq_ctrl.sv
// NxN matrix-multiply sequencer: loads 2*N*N operands, then per result clears the MAC,
// runs N accumulate steps, waits out the MAC latency and hands the result downstream.
module matmul_seq_ctrl #(
  parameter int N       = 3,
  parameter int MAC_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  matmul_seq_if.slave  bus
);
  localparam int IW = $clog2(N*N);
  localparam int LW = $clog2(2*N*N);
  localparam int KW = $clog2(N);

  localparam logic [IW-1:0] NI      = IW'(N);
  localparam logic [LW-1:0] LD_LAST = LW'(2*N*N-1);
  localparam logic [KW-1:0] K_LAST  = KW'(N-1);
  localparam logic [2:0]    W_LAST  = 3'(MAC_LAT-1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLR, S_RUN, S_WAIT, S_OUT, S_DONE
  } state_t;

  state_t        state, state_d;
  logic [LW-1:0] ld_cnt, ld_d;
  logic [KW-1:0] i, i_d, j, j_d, k, k_d;
  logic [2:0]    w, w_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      ld_cnt <= '0;
      i      <= '0;
      j      <= '0;
      k      <= '0;
      w      <= '0;
    end else begin
      state  <= state_d;
      ld_cnt <= ld_d;
      i      <= i_d;
      j      <= j_d;
      k      <= k_d;
      w      <= w_d;
    end
  end

  always_comb begin
    state_d       = state;
    ld_d          = ld_cnt;
    i_d           = i;
    j_d           = j;
    k_d           = k;
    w_d           = w;
    bus.in_ready  = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_sel  = '0;
    bus.mac_clr   = 1'b0;
    bus.mac_en    = 1'b0;
    bus.a_sel     = '0;
    bus.b_sel     = '0;
    bus.out_valid = 1'b0;
    bus.out_idx   = '0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;

    case (state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          state_d = S_LOAD;
          ld_d = '0; i_d = '0; j_d = '0; k_d = '0; w_d = '0;
        end
      end
      S_LOAD: begin
        bus.in_ready = 1'b1;
        bus.load_sel = ld_cnt;
        bus.load_en  = bus.in_valid;
        if (bus.in_valid) begin
          if (ld_cnt == LD_LAST) begin
            ld_d    = '0;
            state_d = S_CLR;
          end else begin
            ld_d = ld_cnt + LW'(1);
          end
        end
      end
      S_CLR: begin
        bus.mac_clr = 1'b1;
        k_d         = '0;
        state_d     = S_RUN;
      end
      S_RUN: begin
        bus.mac_en = 1'b1;
        bus.a_sel  = IW'(i) * NI + IW'(k);
        bus.b_sel  = IW'(k) * NI + IW'(j);
        if (k == K_LAST) begin
          k_d     = '0;
          w_d     = '0;
          state_d = (MAC_LAT > 0) ? S_WAIT : S_OUT;
        end else begin
          k_d = k + KW'(1);
        end
      end
      S_WAIT: begin
        if (w == W_LAST) begin
          w_d     = '0;
          state_d = S_OUT;
        end else begin
          w_d = w + 3'd1;
        end
      end
      S_OUT: begin
        bus.out_valid = 1'b1;
        bus.out_idx   = IW'(i) * NI + IW'(j);
        if (bus.out_ready) begin
          if (i == K_LAST && j == K_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CLR;
            if (j == K_LAST) begin
              j_d = '0;
              i_d = i + KW'(1);
            end else begin
              j_d = j + KW'(1);
            end
          end
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
        i_d = '0; j_d = '0; k_d = '0; w_d = '0; ld_d = '0;
      end
      default: begin
        bus.busy = 1'b0;
        state_d  = S_IDLE;
        i_d = '0; j_d = '0; k_d = '0; w_d = '0; ld_d = '0;
      end
    endcase

    // Abort outranks every transition, including an output handshake in the same cycle.
    if (bus.clear) begin
      state_d = S_IDLE;
      ld_d = '0; i_d = '0; j_d = '0; k_d = '0; w_d = '0;
    end
  end
endmodule
